// File: rtl/traffic_pkg.sv
// Shared light encodings, fault codes and FSM state type for the traffic safety monitor.
package traffic_pkg;

  localparam logic [3:0] CAR_RED        = 4'b0001;
  localparam logic [3:0] CAR_YELLOW     = 4'b0010;
  localparam logic [3:0] CAR_GREEN      = 4'b0100;
  localparam logic [3:0] CAR_GREEN_LEFT = 4'b1100;
  localparam logic [3:0] CAR_LEFT       = 4'b1000;
  localparam logic [3:0] CAR_DARK       = 4'b0000;

  localparam logic [1:0] WALK_RED   = 2'b01;
  localparam logic [1:0] WALK_GREEN = 2'b10;

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_INVALID_0 = 3'd1;
  localparam logic [2:0] CODE_INVALID_1 = 3'd2;
  localparam logic [2:0] CODE_CROSS     = 3'd3;
  localparam logic [2:0] CODE_WALK_0    = 3'd4;
  localparam logic [2:0] CODE_WALK_1    = 3'd5;

  typedef enum logic [1:0] {NORMAL, SUSPECT, FAULT, RECOVER} state_t;

  function automatic logic car_legal(input logic [3:0] car);
    return (car == CAR_RED) || (car == CAR_YELLOW) || (car == CAR_GREEN) ||
           (car == CAR_GREEN_LEFT) || (car == CAR_LEFT);
  endfunction

  function automatic logic walk_legal(input logic [1:0] walk);
    return (walk == WALK_RED) || (walk == WALK_GREEN);
  endfunction

endpackage

// File: rtl/traffic_conflict_check.sv
// Combinational classifier: reports whether the light vectors are illegal and the highest-priority cause.
module traffic_conflict_check
  import traffic_pkg::*;
(
  input  logic [3:0] car_0,
  input  logic [1:0] walk_0,
  input  logic [3:0] car_1,
  input  logic [1:0] walk_1,
  output logic       illegal,
  output logic [2:0] code
);

  // Lower code numbers win when several causes are present at once.
  always_comb begin
    if (!car_legal(car_0) || !walk_legal(walk_0))        code = CODE_INVALID_0;
    else if (!car_legal(car_1) || !walk_legal(walk_1))   code = CODE_INVALID_1;
    else if ((car_0 != CAR_RED) && (car_1 != CAR_RED))   code = CODE_CROSS;
    else if ((walk_0 == WALK_GREEN) && (car_0 != CAR_RED)) code = CODE_WALK_0;
    else if ((walk_1 == WALK_GREEN) && (car_1 != CAR_RED)) code = CODE_WALK_1;
    else                                                 code = CODE_NONE;
  end

  assign illegal = (code != CODE_NONE);

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety filter between the intersection controller and the lamp drivers: pass-through,
// glitch filtering, latched fault with flashing lamps, and operator-cleared all-red recovery.
module traffic_safety_monitor
  import traffic_pkg::*;
#(
  parameter int CONFLICT_CYCLES = 4,
  parameter int FLASH_HALF      = 25000000,
  parameter int ALL_RED_CYCLES  = 100000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] car_in_0,
  input  logic [1:0] walk_in_0,
  input  logic [3:0] car_in_1,
  input  logic [1:0] walk_in_1,
  input  logic       clear_fault,
  output logic [3:0] car_out_0,
  output logic [3:0] car_out_1,
  output logic [1:0] walk_out_0,
  output logic [1:0] walk_out_1,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int CW = $clog2(CONFLICT_CYCLES + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam int RW = $clog2(ALL_RED_CYCLES + 1);
  localparam logic [CW-1:0] CONFLICT_LAST = CW'(CONFLICT_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST    = FW'(FLASH_HALF - 1);
  localparam logic [RW-1:0] RED_LAST      = RW'(ALL_RED_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] conf_cnt, conf_cnt_n;
  logic [FW-1:0] flash_cnt, flash_cnt_n;
  logic [RW-1:0] red_cnt, red_cnt_n;
  logic          flash_on, flash_on_n;
  logic [2:0]    code_n;
  logic [3:0]    car_0_n, car_1_n;
  logic [1:0]    walk_0_n, walk_1_n;
  logic          illegal, load, go_fault;
  logic [2:0]    cause;

  traffic_conflict_check u_check (
    .car_0   (car_in_0),
    .walk_0  (walk_in_0),
    .car_1   (car_in_1),
    .walk_1  (walk_in_1),
    .illegal (illegal),
    .code    (cause)
  );

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can infer a latch.
    state_n     = state;
    conf_cnt_n  = conf_cnt;
    flash_cnt_n = flash_cnt;
    flash_on_n  = flash_on;
    red_cnt_n   = red_cnt;
    code_n      = fault_code;
    car_0_n     = car_out_0;
    car_1_n     = car_out_1;
    walk_0_n    = walk_out_0;
    walk_1_n    = walk_out_1;
    load        = 1'b0;
    go_fault    = 1'b0;

    unique case (state)
      NORMAL: begin
        if (!illegal) load = 1'b1;
        else if (CONFLICT_CYCLES == 1) go_fault = 1'b1;
        else begin
          state_n    = SUSPECT;
          conf_cnt_n = CW'(1);
        end
      end
      SUSPECT: begin
        if (!illegal) begin
          load       = 1'b1;
          conf_cnt_n = '0;
          state_n    = NORMAL;
        end else if (conf_cnt == CONFLICT_LAST) go_fault = 1'b1;
        else conf_cnt_n = conf_cnt + CW'(1);
      end
      FAULT: begin
        if (clear_fault && !illegal) begin
          state_n   = RECOVER;
          red_cnt_n = '0;
          car_0_n   = CAR_RED;
          car_1_n   = CAR_RED;
          walk_0_n  = WALK_RED;
          walk_1_n  = WALK_RED;
        end else begin
          if (flash_cnt == FLASH_LAST) begin
            flash_cnt_n = '0;
            flash_on_n  = !flash_on;
          end else begin
            flash_cnt_n = flash_cnt + FW'(1);
          end
          car_0_n = flash_on_n ? CAR_YELLOW : CAR_DARK;
          car_1_n = flash_on_n ? CAR_RED : CAR_DARK;
        end
      end
      RECOVER: begin
        if (illegal) go_fault = 1'b1;
        else if (red_cnt == RED_LAST) begin
          state_n   = NORMAL;
          red_cnt_n = '0;
        end else begin
          red_cnt_n = red_cnt + RW'(1);
        end
      end
      default: state_n = NORMAL;
    endcase

    if (load) begin
      car_0_n  = car_in_0;
      car_1_n  = car_in_1;
      walk_0_n = walk_in_0;
      walk_1_n = walk_in_1;
    end

    // Fault entry restarts the flash sequence in its "on" phase and latches the new cause.
    if (go_fault) begin
      state_n     = FAULT;
      code_n      = cause;
      conf_cnt_n  = '0;
      flash_cnt_n = '0;
      flash_on_n  = 1'b1;
      car_0_n     = CAR_YELLOW;
      car_1_n     = CAR_RED;
      walk_0_n    = WALK_RED;
      walk_1_n    = WALK_RED;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-high; it is only seen on a clock edge.
    if (rstn) begin
      state      <= NORMAL;
      conf_cnt   <= '0;
      flash_cnt  <= '0;
      flash_on   <= 1'b0;
      red_cnt    <= '0;
      fault_code <= CODE_NONE;
      car_out_0  <= CAR_RED;
      car_out_1  <= CAR_RED;
      walk_out_0 <= WALK_RED;
      walk_out_1 <= WALK_RED;
    end else begin
      state      <= state_n;
      conf_cnt   <= conf_cnt_n;
      flash_cnt  <= flash_cnt_n;
      flash_on   <= flash_on_n;
      red_cnt    <= red_cnt_n;
      fault_code <= code_n;
      car_out_0  <= car_0_n;
      car_out_1  <= car_1_n;
      walk_out_0 <= walk_0_n;
      walk_out_1 <= walk_1_n;
    end
  end

  assign fault = (state == FAULT);

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Directed scoreboard bench for traffic_safety_monitor with short flash and recovery intervals.
module tb_traffic_safety_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] car_in_0, car_in_1;
  logic [1:0] walk_in_0, walk_in_1;
  logic       clear_fault;
  logic [3:0] car_out_0, car_out_1;
  logic [1:0] walk_out_0, walk_out_1;
  logic       fault;
  logic [2:0] fault_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] c0;
    logic [1:0] w0;
    logic [3:0] c1;
    logic [1:0] w1;
    logic       f;
    logic [2:0] code;
  } exp_t;

  exp_t sb[$];

  traffic_safety_monitor #(
    .CONFLICT_CYCLES (3),
    .FLASH_HALF      (4),
    .ALL_RED_CYCLES  (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .car_in_0    (car_in_0),
    .walk_in_0   (walk_in_0),
    .car_in_1    (car_in_1),
    .walk_in_1   (walk_in_1),
    .clear_fault (clear_fault),
    .car_out_0   (car_out_0),
    .car_out_1   (car_out_1),
    .walk_out_0  (walk_out_0),
    .walk_out_1  (walk_out_1),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] c0, input logic [1:0] w0,
                       input logic [3:0] c1, input logic [1:0] w1, input logic clr);
    car_in_0    = c0;
    walk_in_0   = w0;
    car_in_1    = c1;
    walk_in_1   = w1;
    clear_fault = clr;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] c0, input logic [1:0] w0,
                            input logic [3:0] c1, input logic [1:0] w1,
                            input logic f, input logic [2:0] code);
    exp_t e;
    e.tag = tag; e.c0 = c0; e.w0 = w0; e.c1 = c1; e.w1 = w1; e.f = f; e.code = code;
    sb.push_back(e);
  endtask

  // Advance one clock, then compare the registered outputs against the oldest expectation.
  task automatic check_cycle();
    exp_t e;
    logic [11:0] obs_l, exp_l;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      obs_l = {car_out_0, walk_out_0, car_out_1, walk_out_1};
      exp_l = {e.c0, e.w0, e.c1, e.w1};
      assert (obs_l === exp_l) else begin
        errors++;
        $error("FAIL %s lamps: observed %b expected %b", e.tag, obs_l, exp_l);
      end
      checks++;
      assert (fault === e.f) else begin
        errors++;
        $error("FAIL %s fault: observed %b expected %b", e.tag, fault, e.f);
      end
      checks++;
      assert (fault_code === e.code) else begin
        errors++;
        $error("FAIL %s fault_code: observed %0d expected %0d", e.tag, fault_code, e.code);
      end
    end
  endtask

  function automatic logic [3:0] flash0(input int i);
    return ((i / 4) % 2 == 0) ? 4'b0010 : 4'b0000;
  endfunction

  function automatic logic [3:0] flash1(input int i);
    return ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0000;
  endfunction

  initial begin
    rstn = 1'b1;
    drive(4'b0100, 2'b01, 4'b0001, 2'b10, 1'b0);
    expect_out("reset", 4'b0001, 2'b01, 4'b0001, 2'b01, 1'b0, 3'd0);
    check_cycle();

    // Pass-through with one cycle latency, then a mid-stream reset.
    rstn = 1'b0;
    expect_out("pass_a", 4'b0100, 2'b01, 4'b0001, 2'b10, 1'b0, 3'd0);
    check_cycle();
    rstn = 1'b1;
    expect_out("mid_reset", 4'b0001, 2'b01, 4'b0001, 2'b01, 1'b0, 3'd0);
    check_cycle();
    rstn = 1'b0;
    expect_out("pass_b", 4'b0100, 2'b01, 4'b0001, 2'b10, 1'b0, 3'd0);
    check_cycle();

    // Two-cycle cross-conflict glitch is filtered.
    drive(4'b0100, 2'b01, 4'b0100, 2'b01, 1'b0);
    for (int i = 0; i < 2; i++) begin
      expect_out("glitch_hold", 4'b0100, 2'b01, 4'b0001, 2'b10, 1'b0, 3'd0);
      check_cycle();
    end
    drive(4'b0100, 2'b01, 4'b0001, 2'b10, 1'b0);
    expect_out("glitch_resume", 4'b0100, 2'b01, 4'b0001, 2'b10, 1'b0, 3'd0);
    check_cycle();

    // Three-cycle cross conflict becomes a fault with code 3.
    drive(4'b0100, 2'b01, 4'b0100, 2'b01, 1'b0);
    for (int i = 0; i < 2; i++) begin
      expect_out("cross_suspect", 4'b0100, 2'b01, 4'b0001, 2'b10, 1'b0, 3'd0);
      check_cycle();
    end
    for (int i = 0; i < 12; i++) begin
      expect_out("cross_flash", flash0(i), 2'b01, flash1(i), 2'b01, 1'b1, 3'd3);
      check_cycle();
    end

    // Clear with inputs still conflicting is ignored, flashing continues.
    drive(4'b0100, 2'b01, 4'b0100, 2'b01, 1'b1);
    expect_out("clear_ignored", flash0(12), 2'b01, flash1(12), 2'b01, 1'b1, 3'd3);
    check_cycle();
    drive(4'b0100, 2'b01, 4'b0100, 2'b01, 1'b0);
    expect_out("clear_ignored_after", flash0(13), 2'b01, flash1(13), 2'b01, 1'b1, 3'd3);
    check_cycle();

    // Clear with legal inputs: eight all-red recovery cycles, one more red cycle in NORMAL, then pass-through.
    drive(4'b0001, 2'b01, 4'b0100, 2'b01, 1'b1);
    expect_out("recover_red", 4'b0001, 2'b01, 4'b0001, 2'b01, 1'b0, 3'd3);
    check_cycle();
    drive(4'b0001, 2'b01, 4'b0100, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      expect_out("recover_red", 4'b0001, 2'b01, 4'b0001, 2'b01, 1'b0, 3'd3);
      check_cycle();
    end
    expect_out("recover_resume", 4'b0001, 2'b01, 4'b0100, 2'b01, 1'b0, 3'd3);
    check_cycle();

    // Invalid path 0 vector outranks the simultaneous cross conflict.
    drive(4'b0110, 2'b01, 4'b0100, 2'b01, 1'b0);
    for (int i = 0; i < 2; i++) begin
      expect_out("prio_suspect", 4'b0001, 2'b01, 4'b0100, 2'b01, 1'b0, 3'd3);
      check_cycle();
    end
    expect_out("prio_fault", 4'b0010, 2'b01, 4'b0001, 2'b01, 1'b1, 3'd1);
    check_cycle();

    // Into RECOVER, then an unfiltered walk conflict on path 1.
    drive(4'b0001, 2'b01, 4'b0001, 2'b10, 1'b1);
    expect_out("recover2", 4'b0001, 2'b01, 4'b0001, 2'b01, 1'b0, 3'd1);
    check_cycle();
    drive(4'b0001, 2'b01, 4'b0001, 2'b10, 1'b1);
    expect_out("recover2_clear_ignored", 4'b0001, 2'b01, 4'b0001, 2'b01, 1'b0, 3'd1);
    check_cycle();
    drive(4'b0001, 2'b01, 4'b0010, 2'b10, 1'b0);
    expect_out("walk1_fault", 4'b0010, 2'b01, 4'b0001, 2'b01, 1'b1, 3'd5);
    check_cycle();
    expect_out("walk1_flash", 4'b0010, 2'b01, 4'b0001, 2'b01, 1'b1, 3'd5);
    check_cycle();

    // Reset wins while flashing.
    rstn = 1'b1;
    expect_out("fault_reset", 4'b0001, 2'b01, 4'b0001, 2'b01, 1'b0, 3'd0);
    check_cycle();
    rstn = 1'b0;
    drive(4'b1100, 2'b01, 4'b0001, 2'b10, 1'b0);
    expect_out("post_reset_pass", 4'b1100, 2'b01, 4'b0001, 2'b10, 1'b0, 3'd0);
    check_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_safety_monitor.md
Name: traffic_safety_monitor

Overview:
- Sits directly downstream of the two-path intersection controller; consumes both paths' car/walk light vectors before they reach the lamp drivers.
- Passes legal light states through with one registered cycle; filters short glitches; on a persistent illegal/conflicting state latches a fault and forces flashing mode (path 0 flashing yellow, path 1 flashing red, all walks red).
- Exits fault only via an operator clear followed by an all-red interval.

Parameters:
- CONFLICT_CYCLES, 4: consecutive illegal cycles required to declare a fault (>=1).
- FLASH_HALF, 25000000: clock cycles per flash half-period (0.5 s at 50 MHz).
- ALL_RED_CYCLES, 100000000: length of the all-red recovery interval.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset. One clock; reset is synchronous and active-high (asserted = 1).
- car_in_0  in  4  path 0 car lights {left, green, yellow, red}.
- walk_in_0  in  2  path 0 walk lights {green, red}.
- car_in_1  in  4  path 1 car lights, same encoding.
- walk_in_1  in  2  path 1 walk lights.
- clear_fault  in  1  single-cycle operator clear request.
- car_out_0 / car_out_1  out  4  lamp drive, registered.
- walk_out_0 / walk_out_1  out  2  lamp drive, registered.
- fault  out  1  high in FAULT state.
- fault_code  out  3  first cause, latched on FAULT entry.

Behaviour:
- Legal car codes: 0001 red, 0010 yellow, 0100 green, 1100 green+left, 1000 left only; anything else is invalid. Legal walk codes: 01, 10.
- Causes, priority lowest first: 1 invalid path0 vector, 2 invalid path1 vector, 3 cross conflict (both car_in not 0001), 4 walk_in_0 green while car_in_0 not 0001, 5 same for path 1. Code 0 = none.
- Reset: state NORMAL, car_out_* = 0001, walk_out_* = 01, fault = 0, fault_code = 0, counters and flash phase cleared. Reset takes priority in every state, including mid-flash or mid-recovery.
- NORMAL:
  - Inputs legal: outputs <= inputs; latency 1.
  - Illegal input: outputs hold previous value, counter = 1, go to SUSPECT.
  - If CONFLICT_CYCLES = 1, go directly to FAULT.
- SUSPECT:
  - Outputs frozen at last legal values.
  - Illegal input: counter++. When the count reaches CONFLICT_CYCLES, go to FAULT.
  - Legal input: counter cleared, outputs <= inputs, back to NORMAL.
  - Timing: illegal input in cycles t..t+N-1 gives fault = 1 from cycle t+N.
- FAULT:
  - fault = 1. fault_code = highest-priority cause in the triggering cycle, sticky.
  - Flash phase starts "on" and toggles every FLASH_HALF cycles.
  - car_out_0 = on ? 0010 : 0000. car_out_1 = on ? 0001 : 0000. Walks = 01 steady.
  - clear_fault is accepted only if the current inputs are legal; otherwise it is ignored (not remembered).
  - Accepted clear: go to RECOVER.
- RECOVER:
  - fault = 0, fault_code holds last value. Outputs all red (0001/01). Counter counts ALL_RED_CYCLES.
  - Any illegal input: go to FAULT immediately with the new code, no filtering.
  - On completion with legal inputs: go to NORMAL; the next cycle loads the inputs.
  - clear_fault is ignored in RECOVER.
- Entering FAULT from any state resets the flash counter and phase. Counters are wide enough for their parameter; no wrap is permitted within a state.

Decomposition:
- Package traffic_pkg holds:
  - light encoding constants (CAR_RED, CAR_YELLOW, CAR_GREEN, CAR_GREEN_LEFT, CAR_LEFT, WALK_RED, WALK_GREEN);
  - fault code constants;
  - state enum {NORMAL, SUSPECT, FAULT, RECOVER}.
- One combinational sub-module, traffic_conflict_check, maps the four input vectors to {illegal, code[2:0]}.
- FSM, counters and output registers stay in traffic_safety_monitor.

Test Plan (CONFLICT_CYCLES=3, FLASH_HALF=4, ALL_RED_CYCLES=8):
- Reset, then car_in_0=0100, walk_in_0=01, car_in_1=0001, walk_in_1=10 -> outputs match inputs one cycle later, fault=0. Assert rstn mid-stream -> next cycle outputs 0001/01.
- car_in_1=0100 for 2 cycles while car_in_0=0100, then 0001 -> outputs frozen for those 2 cycles, then resume, fault stays 0.
- Same cross conflict held 3 cycles -> fault=1 and fault_code=3 on the 4th cycle. car_out_0 shows 0010 x4, 0000 x4, repeating. car_out_1 shows 0001/0000. Walks = 01.
- car_in_0=0110 held 3 cycles while car_in_1=0100 -> fault_code=1, not 3 (priority).
- In FAULT, pulse clear_fault with inputs still conflicting -> no change. Pulse again with legal inputs -> fault=0, outputs all red 8 cycles, then pass-through resumes.
- In RECOVER, apply walk_in_1=10 with car_in_1=0010 -> immediate FAULT, fault_code=5.
